counter_seq_ctrl: RTL and testbench

- Sequencing controller for the 8-bit up/down counter datapath; drives its 2-bit CTRL command and load value, and observes its count output C.
- Runs a programmed profile: load 0, count up to TARGET, hold, count down to 0, repeated REPEATS times; then pulses DONE.
- Stall watchdog flags a counter that fails to move while commanded.
- Sits between the software/test stimulus layer and the counter instance; shares the counter's CLK/RESET.

---
 rtl/counter_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for an up/down counter: load 0, ramp to a target, hold,
// ramp back to 0, repeat; a stall watchdog traps a counter that ignores commands.
module counter_seq_ctrl #(
  parameter int WIDTH       = 8,
  parameter int HOLD_W      = 8,
  parameter int REP_W       = 4,
  parameter int STALL_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              ABORT,
  input  logic [WIDTH-1:0]  TARGET,
  input  logic [HOLD_W-1:0] HOLD_CYCLES,
  input  logic [REP_W-1:0]  REPEATS,
  input  logic [WIDTH-1:0]  C_IN,
  output logic [1:0]        CTRL,
  output logic [WIDTH-1:0]  LOAD_VAL,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  localparam int STALL_W = $clog2(STALL_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_UP, S_HOLD, S_DOWN, S_DONE, S_ERR
  } state_e;

  typedef enum logic [1:0] {
    CMD_HOLD = 2'b00,
    CMD_UP   = 2'b01,
    CMD_DOWN = 2'b10,
    CMD_LOAD = 2'b11
  } cmd_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    tgt_q, tgt_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [REP_W-1:0]    rep_cnt_q, rep_cnt_d;
  logic [WIDTH-1:0]    prev_c_q, prev_c_d;
  logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
  cmd_e                cmd;
  logic                start_ok;

  assign CTRL     = cmd;
  assign LOAD_VAL = '0;

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    hold_d      = hold_q;
    hold_cnt_d  = hold_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    prev_c_d    = C_IN;
    stall_cnt_d = stall_cnt_q;
    cmd         = CMD_HOLD;
    BUSY        = 1'b0;
    DONE        = 1'b0;
    ERR         = 1'b0;
    start_ok    = START && !ABORT && (state_q == S_IDLE || state_q == S_ERR);

    case (state_q)
      S_IDLE: ;
      S_LOAD: begin
        BUSY    = 1'b1;
        cmd     = CMD_LOAD;
        state_d = S_UP;
      end
      S_UP: begin
        BUSY = 1'b1;
        if (C_IN != tgt_q) begin
          cmd = CMD_UP;
        end else begin
          hold_cnt_d = hold_q;
          state_d    = (hold_q != '0) ? S_HOLD : S_DOWN;
        end
      end
      S_HOLD: begin
        BUSY       = 1'b1;
        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        if (hold_cnt_q <= HOLD_W'(1)) state_d = S_DOWN;
      end
      S_DOWN: begin
        BUSY = 1'b1;
        if (C_IN != '0) begin
          cmd = CMD_DOWN;
        end else begin
          // Further passes go straight back to UP; the counter is already at 0.
          rep_cnt_d = rep_cnt_q - REP_W'(1);
          state_d   = (rep_cnt_q > REP_W'(1)) ? S_UP : S_DONE;
        end
      end
      S_DONE: begin
        DONE    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        ERR = 1'b1;
        if (ABORT) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (start_ok) begin
      tgt_d     = TARGET;
      hold_d    = HOLD_CYCLES;
      rep_cnt_d = (REPEATS == '0) ? REP_W'(1) : REPEATS;
      state_d   = S_LOAD;
    end

    // Watchdog: a commanded counter whose output repeats is counted as stalled.
    if (cmd == CMD_UP || cmd == CMD_DOWN) begin
      if (C_IN == prev_c_q) stall_cnt_d = stall_cnt_q + STALL_W'(1);
      else                  stall_cnt_d = '0;
      if (stall_cnt_d == STALL_W'(STALL_LIMIT)) state_d = S_ERR;
    end

    if ((state_d == S_UP && state_q != S_UP) ||
        (state_d == S_DOWN && state_q != S_DOWN)) begin
      stall_cnt_d = '0;
    end

    // Abort outranks everything, including a watchdog trip in the same cycle.
    if (ABORT && BUSY) begin
      cmd         = CMD_HOLD;
      state_d     = S_IDLE;
      stall_cnt_d = '0;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values of the others; the reset arm is asynchronous.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      tgt_q       <= '0;
      hold_q      <= '0;
      hold_cnt_q  <= '0;
      rep_cnt_q   <= '0;
      prev_c_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      hold_q      <= hold_d;
      hold_cnt_q  <= hold_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      prev_c_q    <= prev_c_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: a counter model closes the loop, and expected CTRL
// sequences are built from the profile arithmetic (load, T ups, hold, T downs).
module tb_counter_seq_ctrl;

  localparam int WIDTH       = 8;
  localparam int HOLD_W      = 8;
  localparam int REP_W       = 4;
  localparam int STALL_LIMIT = 4;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              START;
  logic              ABORT;
  logic [WIDTH-1:0]  TARGET;
  logic [HOLD_W-1:0] HOLD_CYCLES;
  logic [REP_W-1:0]  REPEATS;
  logic [WIDTH-1:0]  C_IN;
  logic [1:0]        CTRL;
  logic [WIDTH-1:0]  LOAD_VAL;
  logic              BUSY;
  logic              DONE;
  logic              ERR;

  logic [WIDTH-1:0]  c_q;
  logic              freeze;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [1:0] exp_q[$];
  logic [1:0] obs_q[$];
  int         obs_done;
  int         obs_peak;
  int         obs_err;
  logic       timed_out;
  string      msg;

  always #5 CLK = ~CLK;

  counter_seq_ctrl #(
    .WIDTH(WIDTH), .HOLD_W(HOLD_W), .REP_W(REP_W), .STALL_LIMIT(STALL_LIMIT)
  ) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT),
    .TARGET(TARGET), .HOLD_CYCLES(HOLD_CYCLES), .REPEATS(REPEATS),
    .C_IN(C_IN), .CTRL(CTRL), .LOAD_VAL(LOAD_VAL),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  // Attached up/down counter, sharing clock and reset; freeze pins its output at 0.
  always @(posedge CLK or posedge RESET) begin
    if (RESET) c_q <= '0;
    else begin
      case (CTRL)
        2'b01:   c_q <= c_q + 8'd1;
        2'b10:   c_q <= c_q - 8'd1;
        2'b11:   c_q <= LOAD_VAL;
        default: c_q <= c_q;
      endcase
    end
  end
  assign C_IN = freeze ? '0 : c_q;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  // Expected BUSY-cycle CTRL stream: 11, then per pass T ups + 00, H holds, T downs + 00.
  task automatic fill_expected(input int t, input int h, input int r);
    int reps;
    reps = (r == 0) ? 1 : r;
    exp_q.delete();
    exp_q.push_back(2'b11);
    for (int p = 0; p < reps; p++) begin
      for (int i = 0; i < t; i++) exp_q.push_back(2'b01);
      exp_q.push_back(2'b00);
      for (int i = 0; i < h; i++) exp_q.push_back(2'b00);
      for (int i = 0; i < t; i++) exp_q.push_back(2'b10);
      exp_q.push_back(2'b00);
    end
  endtask

  function automatic string seq_diff_msg();
    int n;
    logic [1:0] o, e;
    n = (obs_q.size() > exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      o = (i < obs_q.size()) ? obs_q[i] : 2'bxx;
      e = (i < exp_q.size()) ? exp_q[i] : 2'bxx;
      if (o !== e)
        return $sformatf("index %0d observed %b required %b (lengths %0d/%0d)",
                         i, o, e, obs_q.size(), exp_q.size());
    end
    return "";
  endfunction

  // Issues START and records CTRL while BUSY until DONE, then one more cycle.
  task automatic run_profile(input int t, input int h, input int r, input int budget);
    obs_q.delete();
    obs_done  = 0;
    obs_peak  = 0;
    obs_err   = 0;
    timed_out = 1'b1;
    @(negedge CLK);
    START = 1'b1; TARGET = WIDTH'(t); HOLD_CYCLES = HOLD_W'(h); REPEATS = REP_W'(r);
    @(negedge CLK);
    START = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (BUSY) obs_q.push_back(CTRL);
      if (ERR) obs_err++;
      if (int'(C_IN) > obs_peak) obs_peak = int'(C_IN);
      if (DONE) begin
        obs_done++;
        timed_out = 1'b0;
        break;
      end
      @(negedge CLK);
    end
    if (!timed_out) begin
      @(negedge CLK);
      if (DONE || BUSY) obs_done++;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; START = 1'b0; ABORT = 1'b0; freeze = 1'b0;
    TARGET = '0; HOLD_CYCLES = '0; REPEATS = '0;
    #1;
    tests_run++;
    if (CTRL !== 2'b00 || BUSY !== 1'b0 || DONE !== 1'b0 || ERR !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: CTRL=%b BUSY=%b DONE=%b ERR=%b, required 00 0 0 0",
               CTRL, BUSY, DONE, ERR);
    end
    tests_run++;
    if (LOAD_VAL !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_load_val: got %0d, required 0", LOAD_VAL);
    end
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    tests_run++;
    if (BUSY !== 1'b0 || CTRL !== 2'b00) begin
      tests_failed++;
      $display("FAIL idle_after_reset: BUSY=%b CTRL=%b, required 0 00", BUSY, CTRL);
    end
  endtask

  task automatic test_basic_profile();
    fill_expected(5, 3, 1);
    run_profile(5, 3, 1, 100);
    tests_run++;
    if (timed_out) begin
      tests_failed++;
      $display("FAIL basic_timeout: DONE not seen, required within 100 cycles");
    end
    msg = seq_diff_msg();
    tests_run++;
    if (msg != "") begin
      tests_failed++;
      $display("FAIL basic_ctrl_seq: %s", msg);
    end
    tests_run++;
    if (obs_q.size() != 16) begin
      tests_failed++;
      $display("FAIL basic_busy_len: got %0d, required 16", obs_q.size());
    end
    tests_run++;
    if (obs_done != 1) begin
      tests_failed++;
      $display("FAIL basic_done_pulses: got %0d, required 1", obs_done);
    end
    tests_run++;
    if (obs_peak != 5 || C_IN !== 8'd0) begin
      tests_failed++;
      $display("FAIL basic_count_range: peak %0d end %0d, required 5 0", obs_peak, C_IN);
    end
  endtask

  task automatic test_zero_target();
    fill_expected(0, 0, 2);
    run_profile(0, 0, 2, 50);
    msg = seq_diff_msg();
    tests_run++;
    if (timed_out || msg != "") begin
      tests_failed++;
      $display("FAIL zero_ctrl_seq: timeout=%b %s", timed_out, msg);
    end
    tests_run++;
    if (obs_q.size() != 5 || obs_done != 1 || obs_peak != 0) begin
      tests_failed++;
      $display("FAIL zero_profile: busy %0d done %0d peak %0d, required 5 1 0",
               obs_q.size(), obs_done, obs_peak);
    end
  endtask

  task automatic test_full_range();
    int loads;
    fill_expected(255, 1, 3);
    run_profile(255, 1, 3, 2000);
    msg = seq_diff_msg();
    tests_run++;
    if (timed_out || msg != "") begin
      tests_failed++;
      $display("FAIL full_ctrl_seq: timeout=%b %s", timed_out, msg);
    end
    loads = 0;
    foreach (obs_q[i]) if (obs_q[i] == 2'b11) loads++;
    tests_run++;
    if (loads != 1 || obs_done != 1 || obs_err != 0) begin
      tests_failed++;
      $display("FAIL full_profile: loads %0d done %0d err cycles %0d, required 1 1 0",
               loads, obs_done, obs_err);
    end
    tests_run++;
    if (obs_peak != 255 || C_IN !== 8'd0) begin
      tests_failed++;
      $display("FAIL full_count_range: peak %0d end %0d, required 255 0", obs_peak, C_IN);
    end
  endtask

  task automatic test_stall();
    int err_idx;
    freeze = 1'b1;
    @(negedge CLK);
    START = 1'b1; TARGET = 8'd10; HOLD_CYCLES = 8'd0; REPEATS = 4'd1;
    @(negedge CLK);
    START = 1'b0;
    err_idx = -1;
    for (int i = 0; i < 20; i++) begin
      if (ERR) begin
        err_idx = i;
        break;
      end
      @(negedge CLK);
    end
    // One LOAD cycle, then STALL_LIMIT UP cycles that see C repeat, then ERR.
    tests_run++;
    if (err_idx != 1 + STALL_LIMIT) begin
      tests_failed++;
      $display("FAIL stall_err_cycle: ERR at cycle %0d, required %0d", err_idx, 1 + STALL_LIMIT);
    end
    tests_run++;
    if (CTRL !== 2'b00 || BUSY !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_err_outputs: CTRL=%b BUSY=%b, required 00 0", CTRL, BUSY);
    end
    repeat (3) @(negedge CLK);
    tests_run++;
    if (ERR !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_err_sticky: ERR=%b, required 1", ERR);
    end
    freeze = 1'b0;
    fill_expected(3, 0, 1);
    run_profile(3, 0, 1, 100);
    msg = seq_diff_msg();
    tests_run++;
    if (timed_out || msg != "" || obs_err != 0 || ERR !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_rerun: timeout=%b err cycles %0d ERR=%b %s, required clean profile",
               timed_out, obs_err, ERR, msg);
    end
  endtask

  task automatic test_abort();
    int late_done;
    @(negedge CLK);
    START = 1'b1; TARGET = 8'd4; HOLD_CYCLES = 8'd8; REPEATS = 4'd1;
    @(negedge CLK);
    START = 1'b0;
    // Cycle 0 is LOAD, 1..5 UP, HOLD occupies cycles 6..13.
    repeat (8) @(negedge CLK);
    tests_run++;
    if (BUSY !== 1'b1 || CTRL !== 2'b00 || C_IN !== 8'd4) begin
      tests_failed++;
      $display("FAIL abort_in_hold: BUSY=%b CTRL=%b C=%0d, required 1 00 4", BUSY, CTRL, C_IN);
    end
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    tests_run++;
    if (BUSY !== 1'b0 || CTRL !== 2'b00 || DONE !== 1'b0 || C_IN !== 8'd4) begin
      tests_failed++;
      $display("FAIL abort_idle: BUSY=%b CTRL=%b DONE=%b C=%0d, required 0 00 0 4",
               BUSY, CTRL, DONE, C_IN);
    end
    late_done = 0;
    for (int i = 0; i < 15; i++) begin
      if (DONE || BUSY) late_done++;
      @(negedge CLK);
    end
    tests_run++;
    if (late_done != 0) begin
      tests_failed++;
      $display("FAIL abort_no_done: %0d DONE/BUSY cycles, required 0", late_done);
    end
    START = 1'b1; ABORT = 1'b1;
    @(negedge CLK);
    START = 1'b0; ABORT = 1'b0;
    tests_run++;
    if (BUSY !== 1'b0 || CTRL !== 2'b00) begin
      tests_failed++;
      $display("FAIL abort_beats_start: BUSY=%b CTRL=%b, required 0 00", BUSY, CTRL);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    START = 1'b1; TARGET = 8'd10; HOLD_CYCLES = 8'd0; REPEATS = 4'd1;
    @(negedge CLK);
    START = 1'b0;
    repeat (4) @(negedge CLK);
    tests_run++;
    if (C_IN !== 8'd3 || CTRL !== 2'b01) begin
      tests_failed++;
      $display("FAIL reset_mid_setup: C=%0d CTRL=%b, required 3 01", C_IN, CTRL);
    end
    #2 RESET = 1'b1;
    #1;
    tests_run++;
    if (CTRL !== 2'b00 || BUSY !== 1'b0 || ERR !== 1'b0 || DONE !== 1'b0 || C_IN !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_async: CTRL=%b BUSY=%b ERR=%b DONE=%b C=%0d, required 00 0 0 0 0",
               CTRL, BUSY, ERR, DONE, C_IN);
    end
    @(negedge CLK);
    RESET = 1'b0;
    fill_expected(3, 2, 1);
    run_profile(3, 2, 1, 100);
    msg = seq_diff_msg();
    tests_run++;
    if (timed_out || msg != "" || obs_done != 1) begin
      tests_failed++;
      $display("FAIL reset_mid_rerun: timeout=%b done %0d %s, required one clean profile",
               timed_out, obs_done, msg);
    end
  endtask

  task automatic test_random_profiles();
    int t, h, r;
    for (int k = 0; k < 10; k++) begin
      t = $urandom_range(0, 30);
      h = $urandom_range(0, 6);
      r = $urandom_range(0, 3);
      fill_expected(t, h, r);
      run_profile(t, h, r, 600);
      msg = seq_diff_msg();
      tests_run++;
      if (timed_out || msg != "" || obs_done != 1 || obs_err != 0 || obs_peak != t) begin
        tests_failed++;
        $display("FAIL random_profile T=%0d H=%0d R=%0d: timeout=%b done %0d err %0d peak %0d %s",
                 t, h, r, timed_out, obs_done, obs_err, obs_peak, msg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_profile();
    test_zero_target();
    test_full_range();
    test_stall();
    test_abort();
    test_reset_mid();
    test_random_profiles();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
